// File: rtl/game_console_pkg.sv
// Shared types and constants for the game console round control.
package game_console_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REGEN,
    COUNTDOWN,
    RUN,
    PAUSED,
    WIN,
    LOSE
  } round_state_t;

  localparam int unsigned BANNER_W = 2;

  localparam logic [BANNER_W-1:0] BANNER_TITLE = 2'd0;
  localparam logic [BANNER_W-1:0] BANNER_PAUSE = 2'd1;
  localparam logic [BANNER_W-1:0] BANNER_WIN   = 2'd2;
  localparam logic [BANNER_W-1:0] BANNER_LOSE  = 2'd3;

  // Banner shown while the sequencer sits in a given state.
  function automatic logic [BANNER_W-1:0] banner_of(round_state_t s);
    logic [BANNER_W-1:0] b;
    b = BANNER_TITLE;
    case (s)
      PAUSED:  b = BANNER_PAUSE;
      WIN:     b = BANNER_WIN;
      LOSE:    b = BANNER_LOSE;
      default: b = BANNER_TITLE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running timing tick generator; restarts its count on i_clear.
module tick_divider #(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (i_clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  // tick_q tracks (cnt_q == LAST) from a register rather than a compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == LAST);
    end
  end

  assign o_tick = tick_q;

endmodule

// File: rtl/round_sequencer.sv
// Round phase controller: title, level regeneration, countdown, play, pause, result.
module round_sequencer
  import game_console_pkg::*;
#(
  parameter int unsigned RATING_WIDTH = 8,
  parameter int unsigned NUM_IMAGES   = 4,
  parameter int unsigned TICK_DIV     = 25_000_000,
  parameter int unsigned COUNT_TICKS  = 3,
  parameter int unsigned RESULT_TICKS = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  input  logic                          i_pause,
  input  logic                          i_win,
  input  logic                          i_lose,
  input  logic                          i_regen_rdy,
  output logic                          o_regen_req,
  output logic                          o_running,
  output logic [$clog2(NUM_IMAGES)-1:0] o_banner_num,
  output logic [1:0]                    o_countdown,
  output logic [RATING_WIDTH-1:0]       o_rating
);

  localparam int unsigned BW  = $clog2(NUM_IMAGES);
  localparam int unsigned RCW = (RESULT_TICKS > 1) ? $clog2(RESULT_TICKS) : 1;
  localparam logic [RCW-1:0]          RES_LAST   = RCW'(RESULT_TICKS - 1);
  localparam logic [RATING_WIDTH-1:0] RATING_MAX = {RATING_WIDTH{1'b1}};

  round_state_t             state_q, state_d;
  logic [1:0]               cd_q, cd_d;
  logic [RCW-1:0]           res_q, res_d;
  logic [RATING_WIDTH-1:0]  rating_q, rating_d;
  logic                     start_q, pause_q, armed_q;
  logic                     regen_req_q, running_q;
  logic [BW-1:0]            banner_q;
  logic                     start_press, pause_press;
  logic                     tick, tick_clear;

  // armed_q masks the first cycle after reset so a held button is not a press.
  assign start_press = i_start & ~start_q & armed_q;
  assign pause_press = i_pause & ~pause_q & armed_q;

  // Timebase restarts whenever a timed phase is entered.
  assign tick_clear = (state_d != state_q) &&
                      ((state_d == COUNTDOWN) || (state_d == WIN) || (state_d == LOSE));

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_divider (
    .clk     (clk),
    .rst     (rst),
    .i_clear (tick_clear),
    .o_tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    cd_d     = cd_q;
    res_d    = res_q;
    rating_d = rating_q;
    case (state_q)
      IDLE: begin
        if (start_press && !pause_press) begin
          state_d = REGEN;
        end
      end
      REGEN: begin
        if (i_regen_rdy) begin
          state_d = COUNTDOWN;
          cd_d    = 2'(COUNT_TICKS);
        end
      end
      COUNTDOWN: begin
        if (pause_press) begin
          state_d = IDLE;
          cd_d    = 2'd0;
        end else if (tick) begin
          if (cd_q == 2'd1) begin
            state_d = RUN;
            cd_d    = 2'd0;
          end else begin
            cd_d = cd_q - 2'd1;
          end
        end
      end
      RUN: begin
        if (i_lose) begin
          state_d = LOSE;
          res_d   = '0;
          if (rating_q != '0) begin
            rating_d = rating_q - RATING_WIDTH'(1);
          end
        end else if (i_win) begin
          state_d = WIN;
          res_d   = '0;
          if (rating_q != RATING_MAX) begin
            rating_d = rating_q + RATING_WIDTH'(1);
          end
        end else if (pause_press) begin
          state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (pause_press) begin
          state_d = IDLE;
        end else if (start_press) begin
          state_d = RUN;
        end
      end
      WIN, LOSE: begin
        if (start_press && !pause_press) begin
          state_d = REGEN;
        end else if (tick) begin
          if (res_q == RES_LAST) begin
            state_d = REGEN;
          end else begin
            res_d = res_q + RCW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cd_d    = 2'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cd_q        <= 2'd0;
      res_q       <= '0;
      rating_q    <= '0;
      start_q     <= 1'b0;
      pause_q     <= 1'b0;
      armed_q     <= 1'b0;
      regen_req_q <= 1'b0;
      running_q   <= 1'b0;
      banner_q    <= '0;
    end else begin
      state_q     <= state_d;
      cd_q        <= cd_d;
      res_q       <= res_d;
      rating_q    <= rating_d;
      start_q     <= i_start;
      pause_q     <= i_pause;
      armed_q     <= 1'b1;
      regen_req_q <= (state_d == REGEN);
      running_q   <= (state_d == RUN);
      banner_q    <= BW'(banner_of(state_d));
    end
  end

  assign o_regen_req  = regen_req_q;
  assign o_running    = running_q;
  assign o_banner_num = banner_q;
  assign o_countdown  = cd_q;
  assign o_rating     = rating_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: vector table plus hand-written corner sequences.
module tb_round_sequencer;

  typedef struct packed {
    logic       rst;
    logic       start;
    logic       pause;
    logic       win;
    logic       lose;
    logic       rdy;
    logic       regen;
    logic       run;
    logic [1:0] ban;
    logic [1:0] cd;
    logic [7:0] rt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0, i_pause = 1'b0, i_win = 1'b0, i_lose = 1'b0;
  logic       i_regen_rdy = 1'b1;
  logic       o_regen_req, o_running;
  logic [1:0] o_banner_num, o_countdown;
  logic [7:0] o_rating;

  logic [13:0] exp_q[$];
  vec_t        tbl[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  rt_m = 8'd0;

  round_sequencer #(
    .RATING_WIDTH (8),
    .NUM_IMAGES   (4),
    .TICK_DIV     (4),
    .COUNT_TICKS  (3),
    .RESULT_TICKS (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_pause      (i_pause),
    .i_win        (i_win),
    .i_lose       (i_lose),
    .i_regen_rdy  (i_regen_rdy),
    .o_regen_req  (o_regen_req),
    .o_running    (o_running),
    .o_banner_num (o_banner_num),
    .o_countdown  (o_countdown),
    .o_rating     (o_rating)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, s, p, w, l, y, rq, rn,
                              input logic [1:0] b, c, input logic [7:0] t);
    vec_t v;
    v = '{rst: r, start: s, pause: p, win: w, lose: l, rdy: y,
          regen: rq, run: rn, ban: b, cd: c, rt: t};
    return v;
  endfunction

  // Drive one cycle of inputs, queue the expected outputs, compare after the edge.
  task automatic step(input string name, input vec_t v);
    logic [13:0] got, want;
    rst = v.rst; i_start = v.start; i_pause = v.pause;
    i_win = v.win; i_lose = v.lose; i_regen_rdy = v.rdy;
    exp_q.push_back({v.regen, v.run, v.ban, v.cd, v.rt});
    @(posedge clk);
    #1;
    got  = {o_regen_req, o_running, o_banner_num, o_countdown, o_rating};
    want = exp_q.pop_front();
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got regen=%0b run=%0b banner=%0d cd=%0d rating=%0d, want regen=%0b run=%0b banner=%0d cd=%0d rating=%0d",
               name, got[13], got[12], got[11:10], got[9:8], got[7:0],
               want[13], want[12], want[11:10], want[9:8], want[7:0]);
    end
  endtask

  task automatic add(input logic s, p, w, l, y, rq, rn,
                     input logic [1:0] b, c, input logic [7:0] t);
    tbl.push_back(mk(1'b0, s, p, w, l, y, rq, rn, b, c, t));
  endtask

  // Countdown entered in the previous vector: 3,2,1 at 4-cycle spacing, RUN on the 12th.
  task automatic add_countdown(input logic [7:0] t);
    for (int k = 1; k <= 12; k++) begin
      add(0, 0, 0, 0, 1, 0, k == 12, 2'd0,
          (k < 4) ? 2'd3 : (k < 8) ? 2'd2 : (k < 12) ? 2'd1 : 2'd0, t);
    end
  endtask

  task automatic run_countdown(input string name, input logic [7:0] t);
    for (int k = 1; k <= 12; k++) begin
      step(name, mk(0, 0, 0, 0, 0, 1, 0, k == 12, 2'd0,
                    (k < 4) ? 2'd3 : (k < 8) ? 2'd2 : (k < 12) ? 2'd1 : 2'd0, t));
    end
  endtask

  initial begin
    // Main flow: start, win, lose at floor, result timeout, pause/resume, pause-to-idle.
    add(0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 8'd0);
    add(1, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 8'd0);
    add(1, 0, 0, 0, 1, 0, 0, 2'd0, 2'd3, 8'd0);
    add_countdown(8'd0);
    add(0, 0, 1, 0, 1, 0, 0, 2'd2, 2'd0, 8'd1);
    for (int k = 1; k <= 8; k++) begin
      add(0, 0, 1, 1, 1, k == 8, 0, (k == 8) ? 2'd0 : 2'd2, 2'd0, 8'd1);
    end
    add(0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd3, 8'd1);
    add_countdown(8'd1);
    add(0, 1, 1, 1, 1, 0, 0, 2'd3, 2'd0, 8'd0);
    add(1, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 8'd0);
    add(0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd3, 8'd0);
    add_countdown(8'd0);
    add(0, 1, 1, 1, 1, 0, 0, 2'd3, 2'd0, 8'd0);
    for (int k = 1; k <= 8; k++) begin
      add(0, 0, 0, 0, 1, k == 8, 0, (k == 8) ? 2'd0 : 2'd3, 2'd0, 8'd0);
    end
    add(0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd3, 8'd0);
    add_countdown(8'd0);
    add(0, 1, 0, 0, 1, 0, 0, 2'd1, 2'd0, 8'd0);
    add(0, 1, 0, 0, 1, 0, 0, 2'd1, 2'd0, 8'd0);
    add(0, 0, 0, 0, 1, 0, 0, 2'd1, 2'd0, 8'd0);
    add(1, 0, 0, 0, 1, 0, 1, 2'd0, 2'd0, 8'd0);
    add(0, 1, 0, 0, 1, 0, 0, 2'd1, 2'd0, 8'd0);
    add(0, 0, 0, 0, 1, 0, 0, 2'd1, 2'd0, 8'd0);
    add(0, 1, 0, 0, 1, 0, 0, 2'd0, 2'd0, 8'd0);
    add(0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 8'd0);
    add(1, 1, 0, 0, 1, 0, 0, 2'd0, 2'd0, 8'd0);
    add(0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 8'd0);
    add(1, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 8'd0);
    add(0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd3, 8'd0);
    add(0, 1, 0, 0, 1, 0, 0, 2'd0, 2'd0, 8'd0);

    step("reset0", mk(1, 0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 8'd0));
    step("reset1", mk(1, 0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 8'd0));
    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("tbl[%0d]", i), tbl[i]);
    end

    // Regen handshake held off for 50 cycles.
    step("stall_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 8'd0));
    step("stall_enter", mk(0, 1, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 8'd0));
    for (int k = 0; k < 50; k++) begin
      step("stall_hold", mk(0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 8'd0));
    end
    step("stall_rdy", mk(0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd3, 8'd0));
    run_countdown("stall_cd", 8'd0);

    // Rating saturation: 256 consecutive wins, the last one at all-ones.
    rt_m = 8'd0;
    for (int i = 0; i < 256; i++) begin
      rt_m = (rt_m == 8'hFF) ? 8'hFF : rt_m + 8'd1;
      step("sat_win", mk(0, 0, 0, 1, 0, 1, 0, 0, 2'd2, 2'd0, rt_m));
      step("sat_start", mk(0, 1, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, rt_m));
      step("sat_cd", mk(0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd3, rt_m));
      if (i < 255) run_countdown("sat_cd", rt_m);
    end

    // Reset during COUNTDOWN with start held: no press until release and re-press.
    step("rst_mid", mk(1, 1, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 8'd0));
    for (int k = 0; k < 3; k++) begin
      step("rst_held", mk(0, 1, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 8'd0));
    end
    step("rst_release", mk(0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 8'd0));
    step("rst_repress", mk(0, 1, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 8'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
